mem_copy_dma: RTL

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy / fill engine driving a single-port RAM with combinational read.
// One command at a time: copy alternates READ/WRITE per word, fill issues back-to-back WRITEs.
module mem_copy_dma #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  Start,
   input  logic                  Mode,
   input  logic [ADDR_WIDTH-1:0] SrcAddr,
   input  logic [ADDR_WIDTH-1:0] DstAddr,
   input  logic [ADDR_WIDTH-1:0] Length,
   input  logic [DATA_WIDTH-1:0] Pattern,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic                  MemWrite,
   output logic [DATA_WIDTH-1:0] MemWriteData,
   input  logic [DATA_WIDTH-1:0] MemReadData
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e                state_q, state_d;
   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] src_q, dst_q, len_q, cnt_q;
   logic [DATA_WIDTH-1:0] pat_q, data_q;
   logic [ADDR_WIDTH-1:0] cnt_inc;
   logic                  last_word;

   // cnt_q never exceeds Length-1, so the increment cannot wrap even at maximum Length.
   assign cnt_inc   = cnt_q + ADDR_WIDTH'(1);
   assign last_word = (cnt_inc == len_q);

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         mode_q <= 1'b0;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         pat_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         if (state_q == StIdle && Start) begin
            mode_q <= Mode;
            src_q  <= SrcAddr;
            dst_q  <= DstAddr;
            len_q  <= Length;
            pat_q  <= Pattern;
            cnt_q  <= '0;
         end
         if (state_q == StRead) begin
            data_q <= MemReadData;
         end
         if (state_q == StWrite) begin
            cnt_q <= cnt_inc;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               if (Length == '0) begin
                  state_d = StDone;
               end else if (Mode) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = StWrite;
         StWrite: begin
            if (last_word) begin
               state_d = StDone;
            end else if (mode_q) begin
               state_d = StWrite;
            end else begin
               state_d = StRead;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      Busy         = 1'b0;
      Done         = 1'b0;
      MemAddress   = '0;
      MemWrite     = 1'b0;
      MemWriteData = '0;
      unique case (state_q)
         StIdle: ;
         StRead: begin
            Busy       = 1'b1;
            MemAddress = src_q + cnt_q;
         end
         StWrite: begin
            Busy         = 1'b1;
            MemAddress   = dst_q + cnt_q;
            MemWrite     = 1'b1;
            MemWriteData = mode_q ? pat_q : data_q;
         end
         StDone: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
